gbdt_score_accum: RTL and testbench



---
 rtl/gbdt_score_accum.sv | 139 +++++++++++++
 tb/tb_gbdt_score_accum.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbdt_score_accum.sv
// Accumulates streamed leaf values into 8 saturating class scores per round, hands each round to max_result and publishes the winner.
// Scores appear one cycle after a leaf is accepted; leaf_ready is high only while accumulating, and each round waits indefinitely for max_done.
module gbdt_score_accum #(
  parameter int NUM_ROUNDS = 4,
  parameter int SCORE_W    = 32
) (
  input  logic                    gbdt_clk,
  input  logic                    gbdt_rst_n,
  input  logic                    start,
  input  logic                    leaf_valid,
  input  logic [SCORE_W-1:0]      leaf_value,
  input  logic [2:0]              leaf_class,
  input  logic                    leaf_last,
  output logic                    leaf_ready,
  output logic [7:0][SCORE_W-1:0] results,
  output logic [1:0]              round,
  output logic                    max_enable,
  output logic [SCORE_W-1:0]      old_max_result,
  output logic [4:0]              old_max_class,
  input  logic                    max_done,
  input  logic [SCORE_W-1:0]      new_max_result,
  input  logic [4:0]              new_max_class,
  output logic                    busy,
  output logic                    result_valid,
  output logic [4:0]              final_class,
  output logic [SCORE_W-1:0]      final_score
);

  typedef enum logic [1:0] {IDLE, ACCUM, MAXW, FIN} state_t;

  localparam logic [1:0] LAST_ROUND = 2'(NUM_ROUNDS - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic                      w_round_done;
  logic [SCORE_W:0]          w_sum;
  logic [SCORE_W-1:0]        w_sat_sum;

  logic [7:0][SCORE_W-1:0]   r_results;
  logic [1:0]                r_round;
  logic                      r_leaf_ready;
  logic                      r_max_enable;
  logic                      r_busy;
  logic                      r_result_valid;
  logic [SCORE_W-1:0]        r_old_max_result;
  logic [4:0]                r_old_max_class;
  logic [4:0]                r_final_class;
  logic [SCORE_W-1:0]        r_final_score;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_round_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        w_accept = leaf_valid;
        if (leaf_valid && leaf_last) w_state_nxt = MAXW;
      end
      MAXW: begin
        if (max_done) begin
          w_round_done = 1'b1;
          w_state_nxt  = (r_round < LAST_ROUND) ? ACCUM : FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // One extra carry bit detects overflow; the score then pins at all-ones.
  always_comb begin
    w_sum     = {1'b0, r_results[leaf_class]} + {1'b0, leaf_value};
    w_sat_sum = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
  end

  always_ff @(posedge gbdt_clk) begin
    if (!gbdt_rst_n) begin
      r_state          <= IDLE;
      r_results        <= '0;
      r_round          <= '0;
      r_leaf_ready     <= 1'b0;
      r_max_enable     <= 1'b0;
      r_busy           <= 1'b0;
      r_result_valid   <= 1'b0;
      r_old_max_result <= '0;
      r_old_max_class  <= '0;
      r_final_class    <= '0;
      r_final_score    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      // Status flags are registered from the next state so they track it exactly.
      r_leaf_ready   <= (w_state_nxt == ACCUM);
      r_max_enable   <= (w_state_nxt == MAXW);
      r_busy         <= (w_state_nxt != IDLE);
      r_result_valid <= (w_state_nxt == FIN);

      if (r_state == IDLE && start) begin
        r_results        <= '0;
        r_round          <= '0;
        r_old_max_result <= '0;
        r_old_max_class  <= '0;
      end

      if (w_accept) r_results[leaf_class] <= w_sat_sum;

      if (w_round_done) begin
        r_old_max_result <= new_max_result;
        r_old_max_class  <= new_max_class;
        if (r_round < LAST_ROUND) begin
          r_round   <= r_round + 2'd1;
          r_results <= '0;
        end else begin
          r_final_class <= new_max_class;
          r_final_score <= new_max_result;
        end
      end
    end
  end

  assign leaf_ready     = r_leaf_ready;
  assign results        = r_results;
  assign round          = r_round;
  assign max_enable     = r_max_enable;
  assign old_max_result = r_old_max_result;
  assign old_max_class  = r_old_max_class;
  assign busy           = r_busy;
  assign result_valid   = r_result_valid;
  assign final_class    = r_final_class;
  assign final_score    = r_final_score;

endmodule

// File: tb/tb_gbdt_score_accum.sv
// Bench for gbdt_score_accum: a 1-round and a 4-round instance share the leaf bus, each answered by a max_result responder.
// A class-score model with argmax semantics is checked on every max_enable and result_valid cycle.
module tb_gbdt_score_accum;

  logic clk;
  logic rst_n;
  logic start [2];
  logic leaf_valid;
  logic [31:0] leaf_value;
  logic [2:0] leaf_class;
  logic leaf_last;
  logic leaf_ready [2];
  logic max_enable [2];
  logic max_done [2];
  logic busy [2];
  logic result_valid [2];
  logic [7:0][31:0] results [2];
  logic [1:0] round [2];
  logic [31:0] old_max_result [2];
  logic [4:0] old_max_class [2];
  logic [31:0] new_max_result [2];
  logic [4:0] new_max_class [2];
  logic [31:0] final_score [2];
  logic [4:0] final_class [2];

  int checks = 0;
  int errors = 0;
  int act = 1;
  int nr = 4;
  logic [31:0] mdl [32];
  int mdl_round = 0;
  int rv_cnt = 0;
  int en_len = 0;
  int last_en_len = 0;
  int rounds_seen [$];
  int done_delay = 2;

  gbdt_score_accum #(.NUM_ROUNDS(1), .SCORE_W(32)) u_dut1 (
    .gbdt_clk(clk), .gbdt_rst_n(rst_n), .start(start[0]),
    .leaf_valid(leaf_valid), .leaf_value(leaf_value), .leaf_class(leaf_class), .leaf_last(leaf_last),
    .leaf_ready(leaf_ready[0]), .results(results[0]), .round(round[0]), .max_enable(max_enable[0]),
    .old_max_result(old_max_result[0]), .old_max_class(old_max_class[0]), .max_done(max_done[0]),
    .new_max_result(new_max_result[0]), .new_max_class(new_max_class[0]), .busy(busy[0]),
    .result_valid(result_valid[0]), .final_class(final_class[0]), .final_score(final_score[0]));

  gbdt_score_accum #(.NUM_ROUNDS(4), .SCORE_W(32)) u_dut4 (
    .gbdt_clk(clk), .gbdt_rst_n(rst_n), .start(start[1]),
    .leaf_valid(leaf_valid), .leaf_value(leaf_value), .leaf_class(leaf_class), .leaf_last(leaf_last),
    .leaf_ready(leaf_ready[1]), .results(results[1]), .round(round[1]), .max_enable(max_enable[1]),
    .old_max_result(old_max_result[1]), .old_max_class(old_max_class[1]), .max_done(max_done[1]),
    .new_max_result(new_max_result[1]), .new_max_class(new_max_class[1]), .busy(busy[1]),
    .result_valid(result_valid[1]), .final_class(final_class[1]), .final_score(final_score[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", nm, $time);
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    s = 64'(a) + 64'(b);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Best score over classes [0, upto); earlier class wins ties, all-zero gives class 0.
  task automatic mdl_max(input int upto, output logic [4:0] c, output logic [31:0] s);
    c = '0;
    s = '0;
    for (int i = 0; i < upto; i++) begin
      if (mdl[i] > s) begin
        s = mdl[i];
        c = 5'(i);
      end
    end
  endtask

  // max_result stand-in: answers done_delay cycles after max_enable rises, once per enable.
  initial begin
    int rcnt [2];
    bit fired [2];
    logic [31:0] s;
    logic [4:0] c;
    for (int k = 0; k < 2; k++) begin
      max_done[k] = 1'b0; new_max_result[k] = '0; new_max_class[k] = '0;
      rcnt[k] = 0; fired[k] = 1'b0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        max_done[k] = 1'b0;
        if (!max_enable[k]) begin
          rcnt[k] = 0;
          fired[k] = 1'b0;
        end else if (!fired[k]) begin
          rcnt[k]++;
          if (rcnt[k] >= done_delay) begin
            s = old_max_result[k];
            c = old_max_class[k];
            for (int i = 0; i < 8; i++) begin
              if (results[k][i] > s) begin
                s = results[k][i];
                c = 5'({round[k], 3'(i)});
              end
            end
            new_max_result[k] = s;
            new_max_class[k] = c;
            max_done[k] = 1'b1;
            fired[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] c;
    logic [31:0] s;
    if (rst_n && max_enable[act]) begin
      en_len++;
      if (en_len == 1) rounds_seen.push_back(int'(round[act]));
      chk("maxw_round", 64'(round[act]), 64'(mdl_round));
      for (int i = 0; i < 8; i++) chk("maxw_score", 64'(results[act][i]), 64'(mdl[mdl_round*8+i]));
      mdl_max(mdl_round*8, c, s);
      chk("maxw_old_max_result", 64'(old_max_result[act]), 64'(s));
      chk("maxw_old_max_class", 64'(old_max_class[act]), 64'(c));
    end else if (en_len != 0) begin
      last_en_len = en_len;
      en_len = 0;
    end
    if (rst_n && result_valid[act]) begin
      rv_cnt++;
      mdl_max(nr*8, c, s);
      chk("final_class", 64'(final_class[act]), 64'(c));
      chk("final_score", 64'(final_score[act]), 64'(s));
    end
  end

  task automatic do_start(input int k);
    act = k;
    nr = (k == 0) ? 1 : 4;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl_round = 0;
    rv_cnt = 0;
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
  endtask

  task automatic send_leaf(input logic [2:0] c, input logic [31:0] v, input logic l, input bit wait_rd);
    int n;
    leaf_valid = 1'b1; leaf_class = c; leaf_value = v; leaf_last = l;
    n = 0;
    while (!leaf_ready[act] && n < 50) begin @(negedge clk); n++; end
    if (!leaf_ready[act]) timeout("leaf_ready");
    @(posedge clk); #1;
    leaf_valid = 1'b0; leaf_last = 1'b0;
    mdl[mdl_round*8 + int'(c)] = sat_add(mdl[mdl_round*8 + int'(c)], v);
    if (l && wait_rd) begin
      n = 0;
      while (!max_enable[act] && n < 50) begin @(negedge clk); n++; end
      if (!max_enable[act]) timeout("max_enable_rise");
      n = 0;
      while (max_enable[act] && n < 100) begin @(negedge clk); n++; end
      if (max_enable[act]) timeout("max_enable_fall");
      @(posedge clk); #1;
      mdl_round++;
    end
  endtask

  task automatic chk_zero(input int k);
    chk("rst_busy", 64'(busy[k]), 0);
    chk("rst_leaf_ready", 64'(leaf_ready[k]), 0);
    chk("rst_max_enable", 64'(max_enable[k]), 0);
    chk("rst_result_valid", 64'(result_valid[k]), 0);
    chk("rst_round", 64'(round[k]), 0);
    chk("rst_old_max_result", 64'(old_max_result[k]), 0);
    chk("rst_old_max_class", 64'(old_max_class[k]), 0);
    chk("rst_final_class", 64'(final_class[k]), 0);
    chk("rst_final_score", 64'(final_score[k]), 0);
    for (int i = 0; i < 8; i++) chk("rst_results", 64'(results[k][i]), 0);
  endtask

  task automatic finish_chk(input string nm, input logic [4:0] c, input logic [31:0] s);
    repeat (2) @(posedge clk); #1;
    chk({nm, "_pulses"}, 64'(rv_cnt), 1);
    chk({nm, "_class"}, 64'(final_class[act]), 64'(c));
    chk({nm, "_score"}, 64'(final_score[act]), 64'(s));
    chk({nm, "_idle"}, 64'(busy[act]), 0);
  endtask

  task automatic tie_inference();
    do_start(1);
    send_leaf(3'd1, 32'd40, 1'b1, 1'b1);
    send_leaf(3'd4, 32'd40, 1'b1, 1'b1);
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
    leaf_valid = 1'b0; leaf_value = '0; leaf_class = '0; leaf_last = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);

    // Single-round instance
    do_start(0);
    send_leaf(3'd2, 32'd5, 1'b0, 1'b1);
    send_leaf(3'd6, 32'd9, 1'b0, 1'b1);
    send_leaf(3'd2, 32'd7, 1'b1, 1'b1);
    finish_chk("t1", 5'd2, 32'd12);
    chk("t1_res2", 64'(results[0][2]), 12);
    chk("t1_res6", 64'(results[0][6]), 9);

    // Winner in round 2, rounds must step 0..3
    rounds_seen.delete();
    do_start(1);
    send_leaf(3'd5, 32'd50, 1'b1, 1'b1);
    send_leaf(3'd1, 32'd30, 1'b0, 1'b1);
    send_leaf(3'd7, 32'd20, 1'b1, 1'b1);
    send_leaf(3'd3, 32'd60, 1'b0, 1'b1);
    send_leaf(3'd3, 32'd40, 1'b1, 1'b1);
    send_leaf(3'd2, 32'd50, 1'b1, 1'b1);
    finish_chk("t2", 5'd19, 32'd100);
    chk("t2_rounds_n", 64'(rounds_seen.size()), 4);
    for (int i = 0; i < rounds_seen.size() && i < 4; i++) chk("t2_round_seq", 64'(rounds_seen[i]), 64'(i));

    // Saturation
    do_start(1);
    send_leaf(3'd0, 32'hFFFF_FFF0, 1'b0, 1'b1);
    send_leaf(3'd0, 32'h0000_0020, 1'b1, 1'b1);
    chk("t3_mdl_sat", 64'(mdl[0]), 64'h0000_0000_FFFF_FFFF);
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
    finish_chk("t3", 5'd0, 32'hFFFF_FFFF);

    // Tie keeps the earlier class
    tie_inference();
    finish_chk("t4", 5'd1, 32'd40);

    // Reset in the middle of round 1's MAXW
    done_delay = 10;
    do_start(1);
    send_leaf(3'd0, 32'd5, 1'b1, 1'b1);
    send_leaf(3'd2, 32'd7, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_zero(1);
    chk_zero(0);
    repeat (12) @(negedge clk);
    chk("t5_no_result_valid", 64'(rv_cnt), 0);
    chk("t5_idle", 64'(busy[1]), 0);
    done_delay = 2;
    tie_inference();
    finish_chk("t5_restart", 5'd1, 32'd40);

    // Protocol: leaves refused outside ACCUM, start ignored while busy, long max_done wait
    leaf_valid = 1'b1; leaf_class = 3'd0; leaf_value = 32'd99; leaf_last = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t6_idle_leaf_ready", 64'(leaf_ready[1]), 0);
    end
    @(posedge clk); #1 leaf_valid = 1'b0;
    chk("t6_idle_score", 64'(results[1][0]), 64'(mdl[24]));
    do_start(1);
    send_leaf(3'd0, 32'd10, 1'b0, 1'b1);
    @(posedge clk); #1 start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    chk("t6_busy_start_round", 64'(round[1]), 0);
    done_delay = 10;
    send_leaf(3'd0, 32'd5, 1'b0, 1'b1);
    send_leaf(3'd3, 32'd1, 1'b1, 1'b0);
    leaf_valid = 1'b1; leaf_class = 3'd3; leaf_value = 32'd77; leaf_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t6_maxw_leaf_ready", 64'(leaf_ready[1]), 0);
    end
    @(posedge clk); #1 leaf_valid = 1'b0;
    n = 0;
    while (max_enable[1] && n < 50) begin @(negedge clk); n++; end
    if (max_enable[1]) timeout("t6_max_enable_fall");
    @(posedge clk); #1;
    mdl_round++;
    chk("t6_enable_len", 64'(last_en_len), 10);
    chk("t6_mdl_class0", 64'(mdl[0]), 15);
    done_delay = 2;
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
    send_leaf(3'd0, 32'd0, 1'b1, 1'b1);
    finish_chk("t6", 5'd0, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
